// File: rtl/armleocpu_ptw_if.sv
// Single-outstanding read port between the page table walker and the data bus arbiter.
// The walker is the master: it raises m_transaction and holds m_address until m_transaction_done.
interface armleocpu_ptw_if;
   logic        m_transaction;
   logic [33:0] m_address;
   logic        m_transaction_done;
   logic        m_transaction_response;
   logic [31:0] m_rdata;

   modport master (
      output m_transaction,
      output m_address,
      input  m_transaction_done,
      input  m_transaction_response,
      input  m_rdata
   );

   modport slave (
      input  m_transaction,
      input  m_address,
      output m_transaction_done,
      output m_transaction_response,
      output m_rdata
   );
endinterface

// File: rtl/armleocpu_ptw.sv
// Sv32 page table walker: resolves a VPN into a leaf PPN and access tag for the TLB.
//   state  | meaning
//   IDLE   | waiting for resolve_request; result pulse is issued from here
//   LEVEL1 | reading the level-1 PTE indexed by VPN[19:10] from the root table
//   LEVEL0 | reading the level-0 PTE indexed by VPN[9:0] from the pointed-to table
module armleocpu_ptw (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 resolve_request,
   input  logic [19:0]          virtual_address,
   input  logic [21:0]          satp_ppn,
   output logic                 busy,
   output logic                 resolve_done,
   output logic                 resolve_pagefault,
   output logic                 resolve_accessfault,
   output logic [21:0]          resolve_physical_address,
   output logic [7:0]           resolve_access_bits,
   armleocpu_ptw_if.master      mem
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LEVEL1 = 2'd1,
      LEVEL0 = 2'd2
   } state_t;

   state_t      state;
   logic [19:0] vpn_r;
   logic [21:0] satp_r;
   logic [21:0] pte_ppn_r;

   logic pte_v, pte_r, pte_w, pte_x;
   assign pte_v = mem.m_rdata[0];
   assign pte_r = mem.m_rdata[1];
   assign pte_w = mem.m_rdata[2];
   assign pte_x = mem.m_rdata[3];

   // Address is a pure function of registered state, so it cannot move while a read is pending.
   assign busy              = (state != IDLE);
   assign mem.m_transaction = (state != IDLE);
   assign mem.m_address     = (state == LEVEL1) ? {satp_r, vpn_r[19:10], 2'b00}
                                                : {pte_ppn_r, vpn_r[9:0], 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                    <= IDLE;
         vpn_r                    <= '0;
         satp_r                   <= '0;
         pte_ppn_r                <= '0;
         resolve_done             <= 1'b0;
         resolve_pagefault        <= 1'b0;
         resolve_accessfault      <= 1'b0;
         resolve_physical_address <= '0;
         resolve_access_bits      <= '0;
      end else begin
         resolve_done             <= 1'b0;
         resolve_pagefault        <= 1'b0;
         resolve_accessfault      <= 1'b0;
         resolve_physical_address <= '0;
         resolve_access_bits      <= '0;
         case (state)
            IDLE: begin
               if (resolve_request) begin
                  vpn_r  <= virtual_address;
                  satp_r <= satp_ppn;
                  state  <= LEVEL1;
               end
            end
            LEVEL1, LEVEL0: begin
               if (mem.m_transaction_done) begin
                  if (mem.m_transaction_response) begin
                     resolve_done        <= 1'b1;
                     resolve_accessfault <= 1'b1;
                     state               <= IDLE;
                  end else if (!pte_v || (!pte_r && pte_w)) begin
                     resolve_done      <= 1'b1;
                     resolve_pagefault <= 1'b1;
                     state             <= IDLE;
                  end else if (pte_r || pte_x) begin
                     resolve_done <= 1'b1;
                     state        <= IDLE;
                     // A level-1 leaf is a 4 MiB superpage; its low PPN bits must be zero.
                     if (state == LEVEL1 && mem.m_rdata[19:10] != 10'd0) begin
                        resolve_pagefault <= 1'b1;
                     end else begin
                        resolve_access_bits <= mem.m_rdata[7:0];
                        if (state == LEVEL1)
                           resolve_physical_address <= {mem.m_rdata[31:20], vpn_r[9:0]};
                        else
                           resolve_physical_address <= mem.m_rdata[31:10];
                     end
                  end else if (state == LEVEL1) begin
                     pte_ppn_r <= mem.m_rdata[31:10];
                     state     <= LEVEL0;
                  end else begin
                     resolve_done      <= 1'b1;
                     resolve_pagefault <= 1'b1;
                     state             <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_armleocpu_ptw.sv
// Bench for armleocpu_ptw: directed walks from the Sv32 rules plus randomized walks,
// each compared against an arithmetic reference of the two-level lookup.
module tb_armleocpu_ptw;

   logic        clk;
   logic        rst;
   logic        resolve_request;
   logic [19:0] virtual_address;
   logic [21:0] satp_ppn;
   logic        busy;
   logic        resolve_done;
   logic        resolve_pagefault;
   logic        resolve_accessfault;
   logic [21:0] resolve_physical_address;
   logic [7:0]  resolve_access_bits;

   armleocpu_ptw_if mem ();

   armleocpu_ptw dut (
      .clk                      (clk),
      .rst                      (rst),
      .resolve_request          (resolve_request),
      .virtual_address          (virtual_address),
      .satp_ppn                 (satp_ppn),
      .busy                     (busy),
      .resolve_done             (resolve_done),
      .resolve_pagefault        (resolve_pagefault),
      .resolve_accessfault      (resolve_accessfault),
      .resolve_physical_address (resolve_physical_address),
      .resolve_access_bits      (resolve_access_bits),
      .mem                      (mem.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      int          n;
      logic [33:0] a1;
      logic [33:0] a2;
      logic        pf;
      logic        af;
      logic [21:0] phys;
      logic [7:0]  bits;
   } exp_t;

   // Reference walk written with plain arithmetic on page/index numbers.
   function automatic exp_t model(input logic [21:0] satp, input logic [19:0] vpn,
                                  input logic [31:0] p1, input logic e1,
                                  input logic [31:0] p2, input logic e2);
      exp_t x;
      int unsigned vpn1, vpn0;
      vpn1 = int'(vpn) / 1024;
      vpn0 = int'(vpn) % 1024;
      x.n = 1; x.pf = 0; x.af = 0; x.phys = '0; x.bits = '0;
      x.a1 = 34'(satp) * 34'd4096 + 34'(vpn1) * 34'd4;
      x.a2 = 34'(p1 >> 10) * 34'd4096 + 34'(vpn0) * 34'd4;
      if (e1) x.af = 1;
      else if (!p1[0] || (!p1[1] && p1[2])) x.pf = 1;
      else if (p1[1] || p1[3]) begin
         if (((p1 >> 10) % 1024) != 0) x.pf = 1;
         else begin
            x.phys = 22'((p1 >> 20) * 1024 + vpn0);
            x.bits = p1[7:0];
         end
      end else begin
         x.n = 2;
         if (e2) x.af = 1;
         else if (!p2[0] || (!p2[1] && p2[2])) x.pf = 1;
         else if (p2[1] || p2[3]) begin
            x.phys = 22'(p2 >> 10);
            x.bits = p2[7:0];
         end else x.pf = 1;
      end
      return x;
   endfunction

   task automatic walk(input logic [21:0] satp, input logic [19:0] vpn,
                       input logic [31:0] p1, input logic e1,
                       input logic [31:0] p2, input logic e2,
                       input int waits, input bit poke);
      exp_t        x;
      logic [31:0] pd [2];
      logic        ed [2];
      logic [33:0] ad [2];
      x = model(satp, vpn, p1, e1, p2, e2);
      pd[0] = p1; pd[1] = p2; ed[0] = e1; ed[1] = e2; ad[0] = x.a1; ad[1] = x.a2;
      @(negedge clk);
      resolve_request = 1'b1; virtual_address = vpn; satp_ppn = satp;
      @(negedge clk);
      resolve_request = 1'b0;
      check("busy_start", busy, 1);
      for (int r = 0; r < x.n; r++) begin
         for (int w = 0; w < waits; w++) begin
            check("addr_wait", mem.m_address, ad[r]);
            check("txn_wait", mem.m_transaction, 1);
            if (poke) begin
               resolve_request = 1'b1; virtual_address = ~vpn; satp_ppn = ~satp;
            end
            @(negedge clk);
            resolve_request = 1'b0; virtual_address = vpn; satp_ppn = satp;
         end
         check("addr", mem.m_address, ad[r]);
         check("txn", mem.m_transaction, 1);
         mem.m_transaction_done = 1'b1;
         mem.m_transaction_response = ed[r];
         mem.m_rdata = pd[r];
         @(negedge clk);
         mem.m_transaction_done = 1'b0;
         mem.m_transaction_response = 1'b0;
         mem.m_rdata = $urandom;
      end
      check("done", resolve_done, 1);
      check("pagefault", resolve_pagefault, x.pf);
      check("accessfault", resolve_accessfault, x.af);
      check("phys", resolve_physical_address, x.phys);
      check("bits", resolve_access_bits, x.bits);
      check("busy_done", busy, 0);
      check("txn_done", mem.m_transaction, 0);
      @(negedge clk);
      check("done_pulse", resolve_done, 0);
      check("flags_clear", {resolve_pagefault, resolve_accessfault}, 0);
      check("txn_after", mem.m_transaction, 0);
   endtask

   function automatic logic [31:0] rand_pte();
      logic [31:0] p;
      p = $urandom;
      case ($urandom_range(0, 4))
         0: p[3:0] = 4'b0001;
         1: begin p[19:10] = '0; p[1:0] = 2'b11; end
         2: p[1:0] = 2'b11;
         3: p[0] = 1'b1;
         default: ;
      endcase
      return p;
   endfunction

   initial begin
      rst = 1'b1;
      resolve_request = 1'b0; virtual_address = '0; satp_ppn = '0;
      mem.m_transaction_done = 1'b0; mem.m_transaction_response = 1'b0; mem.m_rdata = '0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", resolve_done, 0);
      check("rst_txn", mem.m_transaction, 0);
      check("rst_flags", {resolve_pagefault, resolve_accessfault}, 0);
      check("rst_phys", resolve_physical_address, 0);
      check("rst_bits", resolve_access_bits, 0);
      @(negedge clk);
      rst = 1'b0;

      // Two-level walk, superpage, misaligned superpage.
      walk(22'h00001, 20'h12345, 32'h00000801, 0, 32'h02AF34CF, 0, 0, 0);
      walk(22'h00001, 20'h12345, 32'h003000CF, 0, 32'h0, 0, 0, 0);
      walk(22'h00001, 20'h12345, 32'h003004CF, 0, 32'h0, 0, 0, 0);
      // Invalid and illegal PTEs.
      walk(22'h00001, 20'h12345, 32'h00000000, 0, 32'h0, 0, 0, 0);
      walk(22'h00001, 20'h12345, 32'h00000005, 0, 32'h0, 0, 0, 0);
      walk(22'h00001, 20'h12345, 32'h00000801, 0, 32'h00000801, 0, 0, 0);
      walk(22'h00001, 20'h12345, 32'h00000801, 0, 32'h00000005, 0, 0, 0);
      // Bus errors on each level.
      walk(22'h00001, 20'h12345, 32'h00000801, 1, 32'h02AF34CF, 0, 0, 0);
      walk(22'h00001, 20'h12345, 32'h00000801, 0, 32'h02AF34CF, 1, 0, 0);
      // Wait states, with and without spurious requests mid-walk.
      walk(22'h00001, 20'h12345, 32'h00000801, 0, 32'h02AF34CF, 0, 5, 0);
      walk(22'h00001, 20'h12345, 32'h00000801, 0, 32'h02AF34CF, 0, 5, 1);

      // Reset during the level-0 wait.
      @(negedge clk);
      resolve_request = 1'b1; virtual_address = 20'h12345; satp_ppn = 22'h00001;
      @(negedge clk);
      resolve_request = 1'b0;
      mem.m_transaction_done = 1'b1; mem.m_rdata = 32'h00000801;
      @(negedge clk);
      mem.m_transaction_done = 1'b0;
      @(negedge clk);
      check("l0_wait_txn", mem.m_transaction, 1);
      check("l0_wait_addr", mem.m_address, 34'h2D14);
      rst = 1'b1;
      #1;
      check("rst_mid_txn", mem.m_transaction, 0);
      check("rst_mid_busy", busy, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_mid_nodone", resolve_done, 0);
      end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("post_rst_nodone", resolve_done, 0);
      end
      walk(22'h00001, 20'h12345, 32'h00000801, 0, 32'h02AF34CF, 0, 0, 0);

      // Randomized walks.
      for (int i = 0; i < 60; i++) begin
         walk(22'($urandom), 20'($urandom), rand_pte(), ($urandom_range(0, 7) == 0),
              rand_pte(), ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
              bit'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
